// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared states, pass codes and window packing helpers for the fuzzy window scheduler.
package fuzzy_pkg;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLR     = 3'd1;
   localparam logic [2:0] S_PRIME   = 3'd2;
   localparam logic [2:0] S_FETCH   = 3'd3;
   localparam logic [2:0] S_ISSUE   = 3'd4;
   localparam logic [2:0] S_ROW_END = 3'd5;
   localparam logic PASS_CALIB = 1'b0;
   localparam logic PASS_APPLY = 1'b1;
   localparam int PIX_W = 8;
   localparam int NZ = 9;
   // LSB of z(k) inside win_z, k = 1..9
   function automatic int z_lsb(int k);
      return PIX_W * (k - 1);
   endfunction
   function automatic int clamp_idx(int v, int hi);
      return v < 0 ? 0 : (v > hi ? hi : v);
   endfunction
endpackage

// File: rtl/fuzzy_col_fetch.sv
// fuzzy_col_fetch: reads rows r-1, r, r+1 of one column in 3 cycles plus a drain cycle.
// With FUZZY_SCHED_BORDER_EN the row/column indices are clamped into the frame.
module fuzzy_col_fetch import fuzzy_pkg::*; #(
   parameter int IMG_W  = 21,
   parameter int IMG_H  = 11,
   parameter int ADDR_W = 8,
   parameter int RW     = $clog2(IMG_H),
   parameter int CW     = $clog2(IMG_W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [RW-1:0]        i_row,
   input  logic signed [CW+1:0] i_col,
   input  logic [7:0]           i_rdata,
   output logic                 o_rd_en,
   output logic [ADDR_W-1:0]    o_addr,
   output logic [23:0]          o_col,
   output logic                 o_done
);
   logic [1:0] r_ph;
   logic [7:0] r_top, r_mid;
   int         w_r, w_c;
   always_comb begin
`ifdef FUZZY_SCHED_BORDER_EN
      w_r = clamp_idx(int'(i_row) + int'(r_ph) - 1, IMG_H - 1);
      w_c = clamp_idx(int'(i_col), IMG_W - 1);
`else
      w_r = int'(i_row) + int'(r_ph) - 1;
      w_c = int'(i_col);
`endif
   end
   assign o_rd_en = i_en && r_ph != 2'd3;
   assign o_addr  = o_rd_en ? ADDR_W'(w_r * IMG_W + w_c) : '0;
   assign o_done  = i_en && r_ph == 2'd3;
   // bottom pixel arrives on the drain cycle and is passed straight through
   assign o_col   = {i_rdata, r_mid, r_top};
   always_ff @(posedge clk) begin
      if (rst || !i_en) r_ph <= '0;
      else r_ph <= r_ph + 2'd1;
      if (rst) begin
         r_top <= '0;
         r_mid <= '0;
      end else begin
         if (i_en && r_ph == 2'd1) r_top <= i_rdata;
         if (i_en && r_ph == 2'd2) r_mid <= i_rdata;
      end
   end
endmodule

// File: rtl/fuzzy_win_sched.sv
// fuzzy_win_sched: two-pass (CALIB then APPLY) raster sweep presenting 3x3 windows over valid/ready.
// Define FUZZY_SCHED_BORDER_EN to sweep every pixel with replicate padding.
module fuzzy_win_sched import fuzzy_pkg::*; #(
   parameter int IMG_W  = 21,
   parameter int IMG_H  = 11,
   parameter int ADDR_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [7:0]                 mem_rdata,
   output logic [71:0]                win_z,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [$clog2(IMG_H)-1:0]   win_row,
   output logic [$clog2(IMG_W)-1:0]   win_col,
   output logic                       win_pass,
   output logic                       stats_clr,
   output logic                       busy,
   output logic                       done
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
`ifdef FUZZY_SCHED_BORDER_EN
   localparam int FIRST_ROW = 0;
   localparam int LAST_ROW  = IMG_H - 1;
   localparam int FIRST_COL = 0;
   localparam int LAST_COL  = IMG_W - 1;
`else
   localparam int FIRST_ROW = 1;
   localparam int LAST_ROW  = IMG_H - 2;
   localparam int FIRST_COL = 1;
   localparam int LAST_COL  = IMG_W - 2;
`endif
   logic [2:0]          r_state;
   logic [RW-1:0]       r_row;
   logic [CW-1:0]       r_col;
   logic                r_pass, r_half;
   logic [23:0]         r_cl, r_cm, r_cr;
   logic                w_en, w_done, w_last_row, w_last_col;
   logic [23:0]         w_col;
   logic [23:0]         w_cols [3];
   logic signed [CW+1:0] w_fcol;
   assign w_en       = r_state == S_PRIME || r_state == S_FETCH;
   assign w_last_row = r_row == RW'(LAST_ROW);
   assign w_last_col = r_col == CW'(LAST_COL);
   // PRIME fetches c-1 then c; FETCH fetches c+1
   assign w_fcol = $signed({2'b00, r_col}) +
                   ((r_state == S_PRIME) ? (r_half ? (CW+2)'(0) : '1) : (CW+2)'(1));
   assign win_valid = r_state == S_ISSUE;
   assign stats_clr = r_state == S_CLR;
   assign busy      = r_state != S_IDLE;
   assign done      = r_state == S_ROW_END && w_last_row && r_pass == PASS_APPLY;
   assign win_row   = r_row;
   assign win_col   = r_col;
   assign win_pass  = r_pass;
   assign w_cols    = '{r_cl, r_cm, r_cr};
   always_comb begin
      win_z = '0;
      for (int k = 0; k < NZ; k++) win_z[z_lsb(k + 1) +: PIX_W] = w_cols[k % 3][PIX_W * (k / 3) +: PIX_W];
   end
   fuzzy_col_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RW(RW), .CW(CW)) u_fetch (
      .clk(clk), .rst(rst), .i_en(w_en), .i_row(r_row), .i_col(w_fcol), .i_rdata(mem_rdata),
      .o_rd_en(mem_rd_en), .o_addr(mem_addr), .o_col(w_col), .o_done(w_done)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_pass  <= PASS_CALIB;
         r_half  <= 1'b0;
         r_cl    <= '0;
         r_cm    <= '0;
         r_cr    <= '0;
      end else begin
         if (w_done) begin
            r_cl <= r_cm;
            r_cm <= r_cr;
            r_cr <= w_col;
         end
         case (r_state)
            S_IDLE: if (start) r_state <= S_CLR;
            S_CLR: begin
               r_row   <= RW'(FIRST_ROW);
               r_col   <= CW'(FIRST_COL);
               r_pass  <= PASS_CALIB;
               r_half  <= 1'b0;
               r_state <= S_PRIME;
            end
            S_PRIME: if (w_done) begin
               r_half <= !r_half;
               if (r_half) r_state <= S_FETCH;
            end
            S_FETCH: if (w_done) r_state <= S_ISSUE;
            S_ISSUE: if (win_ready) begin
               if (w_last_col) r_state <= S_ROW_END;
               else begin
                  r_col   <= r_col + CW'(1);
                  r_state <= S_FETCH;
               end
            end
            S_ROW_END: begin
               r_col <= CW'(FIRST_COL);
               if (!w_last_row) begin
                  r_row   <= r_row + RW'(1);
                  r_state <= S_PRIME;
               end else if (r_pass == PASS_CALIB) begin
                  r_row   <= RW'(FIRST_ROW);
                  r_pass  <= PASS_APPLY;
                  r_state <= S_PRIME;
               end else r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fuzzy_win_sched.sv
// tb_fuzzy_win_sched: scoreboard bench on a 4x4 frame; expected windows come from a pixel-level model.
module tb_fuzzy_win_sched;
   localparam int W = 4, H = 4, AW = 8;
`ifdef FUZZY_SCHED_BORDER_EN
   localparam int FR = 0, LR = H - 1, FC = 0, LC = W - 1;
   localparam logic [71:0] FIRST_Z = {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
`else
   localparam int FR = 1, LR = H - 2, FC = 1, LC = W - 2;
   localparam logic [71:0] FIRST_Z = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
`endif
   localparam int NWIN = (LR - FR + 1) * (LC - FC + 1);

   typedef struct { int row; int col; int pass; logic [71:0] z; } win_t;

   logic clk = 0, rst, start, win_ready;
   logic mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0] mem_rdata = 0;
   logic [71:0] win_z;
   logic win_valid, win_pass, stats_clr, busy, done;
   logic [$clog2(H)-1:0] win_row;
   logic [$clog2(W)-1:0] win_col;
   logic [7:0] ram [256];
   win_t q[$];
   int n_checks = 0, n_err = 0, clr_cnt = 0, done_cnt = 0, n_acc = 0, rmode = 0;
   bit exp_done = 0, hold = 0;
   logic [127:0] held;

   fuzzy_win_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .win_z(win_z), .win_valid(win_valid), .win_ready(win_ready),
      .win_row(win_row), .win_col(win_col), .win_pass(win_pass), .stats_clr(stats_clr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];
   always @(posedge clk) begin
      #1;
      if (rmode == 0) win_ready = 1;
      else if (rmode == 1) win_ready = ($urandom_range(0, 2) != 0);
   end

   task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [71:0] model_z(int r, int c);
      logic [71:0] z = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++) begin
            int rr = r + dr - 1, cc = c + dc - 1;
`ifdef FUZZY_SCHED_BORDER_EN
            rr = rr < 0 ? 0 : (rr > H - 1 ? H - 1 : rr);
            cc = cc < 0 ? 0 : (cc > W - 1 ? W - 1 : cc);
`endif
            z[8 * (3 * dr + dc) +: 8] = ram[rr * W + cc];
         end
      return z;
   endfunction

   // scoreboard monitor
   always @(negedge clk) if (!rst) begin
      win_t e;
      if (stats_clr) clr_cnt++;
      if (done || exp_done) chk("done_timing", done, exp_done);
      if (done) done_cnt++;
      exp_done = 0;
      if (win_valid) begin
         chk("no_read_in_issue", mem_rd_en, 0);
         if (hold) chk("stable_under_stall", {win_z, 8'(win_row), 8'(win_col), win_pass}, held);
         if (win_ready) begin
            hold = 0;
            n_checks++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL extra_window: got row %0d col %0d pass %0d required none", win_row, win_col, win_pass);
            end else begin
               e = q.pop_front();
               n_acc++;
               chk("win_z", win_z, e.z);
               chk("win_pos", {16'(win_row), 16'(win_col), 8'(win_pass)}, {16'(e.row), 16'(e.col), 8'(e.pass)});
               if (q.size() == 0) exp_done = 1;
            end
         end else begin
            hold = 1;
            held = {win_z, 8'(win_row), 8'(win_col), win_pass};
         end
      end else if (hold) begin
         hold = 0;
         chk("valid_dropped_unaccepted", 1'b0, 1'b1);
      end
   end

   task automatic start_sweep(bit lat);
      int n = 0;
      for (int p = 0; p < 2; p++)
         for (int r = FR; r <= LR; r++)
            for (int c = FC; c <= LC; c++) q.push_back('{r, c, p, model_z(r, c)});
      clr_cnt = 0; n_acc = 0; done_cnt = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      chk("busy_after_start", busy, 1);
      chk("stats_clr_after_start", stats_clr, 1);
      if (lat) begin
         while (!win_valid && n < 50) begin
            @(posedge clk); #1; n++;
         end
         chk("first_valid_latency", n, 13);
         chk("first_window_z", win_z, FIRST_Z);
      end
   endtask

   task automatic finish_sweep();
      int n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("busy_after_done", busy, 0);
      chk("accept_count", n_acc, 2 * NWIN);
      chk("stats_clr_count", clr_cnt, 1);
      chk("queue_empty", q.size(), 0);
   endtask

   initial begin
      int n;
      rst = 1; start = 0; win_ready = 1;
      for (int a = 0; a < 256; a++) ram[a] = 8'(a);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {mem_rd_en, mem_addr, win_z, win_valid, win_row, win_col, win_pass, stats_clr, busy, done}, 0);
      @(posedge clk); #1 rst = 0;

      // full run with latency and first-window checks
      start_sweep(1);
      finish_sweep();

      // backpressure on window 2 plus an ignored start while busy
      rmode = 2; win_ready = 1;
      start_sweep(0);
      n = 0;
      while (!(win_valid && n_acc == 1) && n < 500) begin
         @(posedge clk); #1; n++;
      end
      chk("reach_window2", n < 500, 1);
      win_ready = 0; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (4) @(posedge clk);
      #1 win_ready = 1; rmode = 0;
      finish_sweep();

      // reset during third window of pass 1
      start_sweep(0);
      n = 0;
      while (!(win_valid && n_acc == NWIN + 2) && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("reach_pass1_window3", n < 1000, 1);
      rst = 1;
      @(posedge clk); @(negedge clk);
      chk("abort_outputs", {mem_rd_en, mem_addr, win_z, win_valid, win_row, win_col, win_pass, stats_clr, busy, done}, 0);
      chk("abort_no_done", done_cnt, 0);
      q.delete(); exp_done = 0; hold = 0;
      @(posedge clk); #1 rst = 0;
      start_sweep(1);
      finish_sweep();

      // randomized frames and backpressure
      rmode = 1;
      for (int t = 0; t < 4; t++) begin
         for (int a = 0; a < W * H; a++) ram[a] = 8'($urandom);
         start_sweep(0);
         finish_sweep();
      end
      rmode = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
